// File: rtl/wave_synth_controller.sv
// wave_synth_controller: DDS-based multi-mode waveform synthesiser.
// Phase accumulator with runtime step, triangle/sawtooth/square sample
// generation, PWM of the current sample, buzzer square wave, and a mode
// FSM that defers mode changes to the next period boundary.
// Optional feature macro: WAVEGEN_AMPLITUDE_EN (adds amplitude scaling
// stage and the amplitude port; sample latency becomes 2).
module wave_synth_controller #(
  parameter int WIDTH       = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int BUZZER_FREQ = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           mode_select,
  input  logic [ACC_WIDTH-1:0] phase_inc,
`ifdef WAVEGEN_AMPLITUDE_EN
  input  logic [WIDTH-1:0]     amplitude,
`endif
  output logic [WIDTH-1:0]     R2R_out,
  output logic                 pwm_out,
  output logic                 buzzer_out,
  output logic                 period_tick,
  output logic [2:0]           active_mode
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [2:0] MODE_OFF = 3'd0;
  localparam logic [2:0] MODE_TRI = 3'd1;
  localparam logic [2:0] MODE_SAW = 3'd2;
  localparam logic [2:0] MODE_SQR = 3'd3;
  localparam logic [2:0] MODE_BUZ = 3'd4;

  localparam int BUZ_HALF_RAW = CLOCK_FREQ / (2 * BUZZER_FREQ);
  localparam int BUZ_HALF     = (BUZ_HALF_RAW < 1) ? 1 : BUZ_HALF_RAW;
  localparam int BCNT_W       = $clog2(BUZ_HALF + 1);
  localparam logic [BCNT_W-1:0] BUZ_LAST = BCNT_W'(BUZ_HALF - 1);

  // Waveform lookup from the top bits of the phase.
  function automatic logic [WIDTH-1:0] f_sample(input logic [2:0] mode,
                                                input logic [ACC_WIDTH-1:0] acc);
    logic [WIDTH:0] p;
    p = acc[ACC_WIDTH-1 -: WIDTH+1];
    case (mode)
      MODE_TRI: f_sample = p[WIDTH] ? ~p[WIDTH-1:0] : p[WIDTH-1:0];
      MODE_SAW: f_sample = acc[ACC_WIDTH-1 -: WIDTH];
      MODE_SQR: f_sample = {WIDTH{acc[ACC_WIDTH-1]}};
      default:  f_sample = '0;
    endcase
  endfunction

`ifdef WAVEGEN_AMPLITUDE_EN
  // Truncating scale: (s * a) >> WIDTH, so full-scale amplitude is 2^WIDTH-1/2^WIDTH.
  function automatic logic [WIDTH-1:0] f_scale(input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] a);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, s} * {{WIDTH{1'b0}}, a};
    f_scale = prod[2*WIDTH-1:WIDTH];
  endfunction
`endif

  logic [1:0]           r_state, w_state_nxt;
  logic [2:0]           r_active, w_active_nxt, w_req;
  logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_carry, w_tick_nxt, r_tick;
  logic [WIDTH-1:0]     r_sample_p1;
  logic [WIDTH-1:0]     r_pwm_cnt, r_duty;
  logic                 r_pwm;
  logic [BCNT_W-1:0]    r_bcnt;
  logic                 r_buz;

  assign w_req   = (mode_select > MODE_BUZ) ? MODE_OFF : mode_select;
  assign w_sum   = {1'b0, r_acc} + {1'b0, phase_inc};
  assign w_carry = w_sum[ACC_WIDTH];

  // Mode FSM next-state: immediate OFF, deferred switch to other modes until carry.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_acc_nxt    = r_acc;
    case (r_state)
      ST_IDLE: begin
        if (w_req != MODE_OFF) begin
          w_active_nxt = w_req;
          w_acc_nxt    = '0;
          w_state_nxt  = ST_RUN;
        end
      end
      ST_RUN: begin
        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
        if (w_req == MODE_OFF) begin
          w_active_nxt = MODE_OFF;
          w_state_nxt  = ST_IDLE;
        end else if (w_req != r_active) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        w_acc_nxt = w_sum[ACC_WIDTH-1:0];
        if (w_req == MODE_OFF) begin
          w_active_nxt = MODE_OFF;
          w_state_nxt  = ST_IDLE;
        end else if (w_req == r_active) begin
          w_state_nxt = ST_RUN;
        end else if ((phase_inc == '0) || w_carry) begin
          // A zero step never wraps, so commit without waiting.
          w_active_nxt = w_req;
          w_acc_nxt    = '0;
          w_state_nxt  = ST_RUN;
        end
      end
      default: begin
        w_active_nxt = MODE_OFF;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // The tick is suppressed on the edge that drops into IDLE.
  assign w_tick_nxt = (r_state != ST_IDLE) && w_carry && (w_state_nxt != ST_IDLE);

  // Stage p0: control state, accumulator and period tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_active <= MODE_OFF;
      r_acc    <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_acc    <= w_acc_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  // Stage p1: raw sample from the applied mode and current phase.
  always_ff @(posedge clk) begin
    if (reset) r_sample_p1 <= '0;
    else       r_sample_p1 <= f_sample(r_active, r_acc);
  end

`ifdef WAVEGEN_AMPLITUDE_EN
  logic [WIDTH-1:0] r_scaled_p2;
  // Stage p2: amplitude scaling, amplitude sampled every clock.
  always_ff @(posedge clk) begin
    if (reset) r_scaled_p2 <= '0;
    else       r_scaled_p2 <= f_scale(r_sample_p1, amplitude);
  end
  assign R2R_out = r_scaled_p2;
`else
  assign R2R_out = r_sample_p1;
`endif

  // PWM: free-running counter, duty latched only at frame start to avoid glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (&r_pwm_cnt) r_duty <= R2R_out;
      r_pwm     <= (r_pwm_cnt < r_duty);
    end
  end

  // Buzzer: half-period counter runs only while BUZZER is (being) applied.
  always_ff @(posedge clk) begin
    if (reset || (w_active_nxt != MODE_BUZ)) begin
      r_bcnt <= '0;
      r_buz  <= 1'b0;
    end else if (r_bcnt == BUZ_LAST) begin
      r_bcnt <= '0;
      r_buz  <= ~r_buz;
    end else begin
      r_bcnt <= r_bcnt + 1'b1;
    end
  end

  assign pwm_out     = r_pwm;
  assign buzzer_out  = r_buz;
  assign period_tick = r_tick;
  assign active_mode = r_active;

endmodule

// File: tb/tb_wave_synth_controller.sv
// Scoreboard bench for wave_synth_controller (WIDTH=8, ACC_WIDTH=16,
// CLOCK_FREQ=1000, BUZZER_FREQ=100). A behavioural model predicts every
// cycle's outputs; a monitor pops and compares on the falling edge.
module tb_wave_synth_controller;
  localparam int WIDTH       = 8;
  localparam int ACC_WIDTH   = 16;
  localparam int CLOCK_FREQ  = 1000;
  localparam int BUZZER_FREQ = 100;
  localparam int HALF        = CLOCK_FREQ / (2 * BUZZER_FREQ);
  localparam int ACC_MOD     = 1 << ACC_WIDTH;
  localparam int SMAX        = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       mode_select = 3'd0;
  logic [15:0]      phase_inc = 16'd0;
  logic [7:0]       amplitude = 8'd0;
  logic [7:0]       R2R_out;
  logic             pwm_out, buzzer_out, period_tick;
  logic [2:0]       active_mode;

  wave_synth_controller #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH),
    .CLOCK_FREQ(CLOCK_FREQ), .BUZZER_FREQ(BUZZER_FREQ)
  ) dut (
    .clk(clk), .reset(reset), .mode_select(mode_select), .phase_inc(phase_inc),
`ifdef WAVEGEN_AMPLITUDE_EN
    .amplitude(amplitude),
`endif
    .R2R_out(R2R_out), .pwm_out(pwm_out), .buzzer_out(buzzer_out),
    .period_tick(period_tick), .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r2r; int pwm; int buz; int tick; int act;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_ticks = 0;

  // Model state: what the synthesiser should hold after each edge.
  int m_act = 0, m_acc = 0, m_sample = 0, m_scaled = 0;
  int m_pcnt = 0, m_duty = 0, m_pwm = 0, m_buz = 0, m_bcnt = 0, m_tick = 0;
  bit m_running = 0, m_waiting = 0;

  // Ideal waveform value for a mode at a given phase.
  function automatic int wave(input int mode, input int acc);
    int q;
    q = acc >> (ACC_WIDTH - WIDTH - 1);
    case (mode)
      1: wave = (q <= SMAX) ? q : (2 * SMAX + 1 - q);
      2: wave = acc >> (ACC_WIDTH - WIDTH);
      3: wave = (acc >= ACC_MOD / 2) ? SMAX : 0;
      default: wave = 0;
    endcase
  endfunction

  task automatic model_step();
    int req, sum, nact, nacc, r2r_now, nsample, nscaled;
    bit carry, nrun, nwait;
    r2r_now = m_sample;
`ifdef WAVEGEN_AMPLITUDE_EN
    r2r_now = m_scaled;
`endif
    if (reset) begin
      m_act = 0; m_acc = 0; m_sample = 0; m_scaled = 0; m_pcnt = 0; m_duty = 0;
      m_pwm = 0; m_buz = 0; m_bcnt = 0; m_tick = 0; m_running = 0; m_waiting = 0;
    end else begin
      req   = (int'(mode_select) > 4) ? 0 : int'(mode_select);
      sum   = m_acc + int'(phase_inc);
      carry = m_running && (sum >= ACC_MOD);
      nact = m_act; nacc = m_acc; nrun = m_running; nwait = m_waiting;
      if (!m_running) begin
        if (req != 0) begin nact = req; nacc = 0; nrun = 1; nwait = 0; end
      end else begin
        nacc = sum % ACC_MOD;
        if (req == 0) begin nact = 0; nrun = 0; nwait = 0; end
        else if (req == m_act) nwait = 0;
        else if (m_waiting && (phase_inc == 0 || carry)) begin
          nact = req; nacc = 0; nwait = 0;
        end else nwait = 1;
      end
      nsample = wave(m_act, m_acc);
      nscaled = (m_sample * int'(amplitude)) >> WIDTH;
      m_pwm   = (m_pcnt < m_duty) ? 1 : 0;
      if (m_pcnt == SMAX) m_duty = r2r_now;
      m_pcnt  = (m_pcnt + 1) % (SMAX + 1);
      if (nact != 4) begin m_bcnt = 0; m_buz = 0; end
      else if (m_bcnt == HALF - 1) begin m_bcnt = 0; m_buz = 1 - m_buz; end
      else m_bcnt = m_bcnt + 1;
      m_tick = (carry && nrun) ? 1 : 0;
      m_act = nact; m_acc = nacc; m_running = nrun; m_waiting = nwait;
      m_sample = nsample; m_scaled = nscaled;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.r2r = m_sample;
`ifdef WAVEGEN_AMPLITUDE_EN
    e.r2r = m_scaled;
`endif
    e.pwm = m_pwm; e.buz = m_buz; e.tick = m_tick; e.act = m_act;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      push_exp();
      #1;
`ifdef WAVEGEN_AMPLITUDE_EN
      amplitude = 8'($urandom_range(0, 255));
`endif
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0d required %0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expectation per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("R2R_out", 32'(R2R_out), e.r2r);
        chk("pwm_out", 32'(pwm_out), e.pwm);
        chk("buzzer_out", 32'(buzzer_out), e.buz);
        chk("period_tick", 32'(period_tick), e.tick);
        chk("active_mode", 32'(active_mode), e.act);
        if (period_tick === 1'b1) n_ticks++;
      end
    end
  end

  initial begin
    int k;
    reset = 1'b1;
    run(3);
    reset = 1'b0;
    // Sawtooth ramp, one LSB per clock.
    mode_select = 3'd2; phase_inc = 16'd256;
    run(600);
    // Triangle, period 128 clocks (deferred switch from sawtooth).
    mode_select = 3'd1; phase_inc = 16'd512;
    run(400);
    // Sawtooth, then square requested mid-ramp.
    mode_select = 3'd0; run(2);
    mode_select = 3'd2; phase_inc = 16'd256; run(102);
    mode_select = 3'd3; run(500);
    // Slow square so the duty register sees full scale.
    phase_inc = 16'd64; run(1500);
    // Buzzer then OFF.
    mode_select = 3'd4; run(60);
    mode_select = 3'd0; run(10);
    // Pending request withdrawn.
    mode_select = 3'd2; phase_inc = 16'd256; run(40);
    mode_select = 3'd3; run(5);
    mode_select = 3'd2; run(300);
    // Pending with zero step commits next cycle.
    mode_select = 3'd3; run(1);
    phase_inc = 16'd0; run(3);
    // Reset while pending.
    mode_select = 3'd1; phase_inc = 16'd256; run(1);
    reset = 1'b1; run(1);
    reset = 1'b0; mode_select = 3'd0; run(3);
    // Randomised segments, including out-of-range modes and max step.
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 14) == 0) begin
        reset = 1'b1; run($urandom_range(1, 3)); reset = 1'b0;
      end
      mode_select = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 9);
      if (k == 0)      phase_inc = 16'd0;
      else if (k == 1) phase_inc = 16'hFFFF;
      else if (k < 6)  phase_inc = 16'($urandom_range(1, 1024));
      else             phase_inc = 16'($urandom_range(1024, 8192));
      run($urandom_range(1, 200));
    end
    mode_select = 3'd0;
    run(2);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    n_cmp++;
    if (n_ticks == 0) begin
      n_bad++;
      $display("FAIL period_tick_seen: got %0d required >0", n_ticks);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
